// File: rtl/mul_mdc_tcdm_arbiter_pkg.sv
// Shared types and defaults for the mul_mdc TCDM arbiter.
// Optional feature macro: MUL_MDC_ARB_PRIO_EN (see mul_mdc_tcdm_arbiter.sv).
package mul_mdc_package;

    localparam int unsigned ARB_NR_DEFAULT    = 4;
    localparam int unsigned ARB_OUTST_DEFAULT = 4;

    // Requester index width for the default configuration.
    localparam int unsigned ARB_IDX_W = $clog2(ARB_NR_DEFAULT);
    typedef logic [ARB_IDX_W-1:0] arb_idx_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    // Index width for an arbitrary requester count (at least one bit).
    function automatic int unsigned arb_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_mdc_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding TCDM transactions.
// clear_i flushes the contents and wins over a push/pop in the same cycle.
module mul_mdc_arb_id_fifo
    import mul_mdc_package::*;
#(
    parameter int unsigned WIDTH = ARB_IDX_W,
    parameter int unsigned DEPTH = ARB_OUTST_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Next-state: pointer/count update, clear has priority.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            end
            cnt_d = cnt_q + (PtrW+1)'(push_ok) - (PtrW+1)'(pop_ok);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_mdc_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among NR streamer requesters.
// Responses are routed back in order via an ID FIFO.
// Optional macro MUL_MDC_ARB_PRIO_EN: requester 0 gets fixed top priority in ARB_IDLE.
module mul_mdc_tcdm_arbiter
    import mul_mdc_package::*;
#(
    parameter int unsigned NR        = ARB_NR_DEFAULT,
    parameter int unsigned MAX_OUTST = ARB_OUTST_DEFAULT,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic [NR-1:0]              req_i,
    output logic [NR-1:0]              gnt_o,
    input  logic [NR-1:0][AW-1:0]      add_i,
    input  logic [NR-1:0]              wen_i,
    input  logic [NR-1:0][DW/8-1:0]    be_i,
    input  logic [NR-1:0][DW-1:0]      data_i,
    output logic [DW-1:0]              r_data_o,
    output logic [NR-1:0]              r_valid_o,
    output logic                       tcdm_req_o,
    input  logic                       tcdm_gnt_i,
    output logic [AW-1:0]              tcdm_add_o,
    output logic                       tcdm_wen_o,
    output logic [DW/8-1:0]            tcdm_be_o,
    output logic [DW-1:0]              tcdm_data_o,
    input  logic [DW-1:0]              tcdm_r_data_i,
    input  logic                       tcdm_r_valid_i,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int unsigned IdxW = arb_idx_width(NR);

    arb_state_t      state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] sel_q, sel_d;
    logic            err_q, err_d;

    logic [IdxW-1:0] sel;
    logic [IdxW-1:0] owner;
    logic            tcdm_req;
    logic            hs;
    logic            pop;
    logic            fifo_full, fifo_empty;
    logic [IdxW-1:0] fifo_head;
    logic            rr_upd;

    // Round-robin pick starting at rr_ptr; optional fixed priority for requester 0.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
`ifdef MUL_MDC_ARB_PRIO_EN
        if (req_i[0]) begin
            found = 1'b1;
        end
`endif
        for (int unsigned i = 0; i < NR; i++) begin
            idx = (32'(rr_ptr_q) + i) % NR;
            if (!found && req_i[IdxW'(idx)]) begin
                sel   = IdxW'(idx);
                found = 1'b1;
            end
        end
    end

    // State register plus pointer, locked selection and sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
        end
    end

    // Next-state: enter ARB_WAIT on an ungranted request, leave on grant.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        err_d    = err_q | (tcdm_r_valid_i & fifo_empty);
        unique case (state_q)
            ARB_IDLE: begin
                if (tcdm_req && !tcdm_gnt_i) begin
                    state_d = ARB_WAIT;
                    sel_d   = sel;
                end
            end
            ARB_WAIT: begin
                if (tcdm_gnt_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (hs && rr_upd) begin
            rr_ptr_d = (owner == IdxW'(NR-1)) ? '0 : owner + 1'b1;
        end
        if (clear_i) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = '0;
            err_d    = 1'b0;
        end
    end

    // Outputs: payload mux, grant/response decode; everything forced low in reset.
    always_comb begin
        tcdm_req    = (state_q == ARB_WAIT) ? 1'b1 : (|req_i) & ~fifo_full;
        owner       = (state_q == ARB_WAIT) ? sel_q : sel;
        hs          = tcdm_req & tcdm_gnt_i;
        pop         = tcdm_r_valid_i & ~fifo_empty;
`ifdef MUL_MDC_ARB_PRIO_EN
        rr_upd      = (owner != '0);
`else
        rr_upd      = 1'b1;
`endif
        gnt_o       = '0;
        r_valid_o   = '0;
        r_data_o    = '0;
        tcdm_req_o  = 1'b0;
        tcdm_add_o  = '0;
        tcdm_wen_o  = 1'b0;
        tcdm_be_o   = '0;
        tcdm_data_o = '0;
        busy_o      = 1'b0;
        if (!rst_i) begin
            tcdm_req_o       = tcdm_req;
            gnt_o[owner]     = hs;
            r_valid_o[fifo_head] = pop;
            r_data_o         = tcdm_r_data_i;
            busy_o           = ~fifo_empty | (state_q == ARB_WAIT);
            if (tcdm_req) begin
                tcdm_add_o  = add_i[owner];
                tcdm_wen_o  = wen_i[owner];
                tcdm_be_o   = be_i[owner];
                tcdm_data_o = data_i[owner];
            end
        end
    end

    assign err_o = err_q;

    mul_mdc_arb_id_fifo #(
        .WIDTH (IdxW),
        .DEPTH (MAX_OUTST)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (hs),
        .data_i  (owner),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_mul_mdc_tcdm_arbiter.sv
// Directed bench for mul_mdc_tcdm_arbiter (default NR=4, MAX_OUTST=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mul_mdc_tcdm_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned MAX_OUTST = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clear;
    logic [NR-1:0]           req;
    logic [NR-1:0]           gnt;
    logic [NR-1:0][AW-1:0]   add;
    logic [NR-1:0]           wen;
    logic [NR-1:0][DW/8-1:0] be;
    logic [NR-1:0][DW-1:0]   wdata;
    logic [DW-1:0]           r_data;
    logic [NR-1:0]           r_valid;
    logic                    tcdm_req;
    logic                    tcdm_gnt;
    logic [AW-1:0]           tcdm_add;
    logic                    tcdm_wen;
    logic [DW/8-1:0]         tcdm_be;
    logic [DW-1:0]           tcdm_data;
    logic [DW-1:0]           tcdm_r_data;
    logic                    tcdm_r_valid;
    logic                    busy;
    logic                    err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mul_mdc_tcdm_arbiter #(
        .NR (NR), .MAX_OUTST (MAX_OUTST), .AW (AW), .DW (DW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .req_i          (req),
        .gnt_o          (gnt),
        .add_i          (add),
        .wen_i          (wen),
        .be_i           (be),
        .data_i         (wdata),
        .r_data_o       (r_data),
        .r_valid_o      (r_valid),
        .tcdm_req_o     (tcdm_req),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_add_o     (tcdm_add),
        .tcdm_wen_o     (tcdm_wen),
        .tcdm_be_o      (tcdm_be),
        .tcdm_data_o    (tcdm_data),
        .tcdm_r_data_i  (tcdm_r_data),
        .tcdm_r_valid_i (tcdm_r_valid),
        .busy_o         (busy),
        .err_o          (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic set_payloads;
        for (int i = 0; i < int'(NR); i++) begin
            add[i]   = 32'h1000 + 32'(i) * 4;
            wen[i]   = i[0];
            be[i]    = 4'hF;
            wdata[i] = 32'hD000 + 32'(i);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; clear = 1'b0; req = 4'b1111; tcdm_gnt = 1'b1;
        tcdm_r_valid = 1'b1; tcdm_r_data = 32'hDEAD;
        set_payloads();
        #2;
        total++; if (tcdm_req !== 1'b0) begin bad++; $display("FAIL reset_tcdm_req: got %0b want 0", tcdm_req); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        total++; if (r_valid !== 4'b0000) begin bad++; $display("FAIL reset_r_valid: got %b want 0000", r_valid); end
        total++; if (r_data !== 32'h0) begin bad++; $display("FAIL reset_r_data: got %h want 0", r_data); end
        total++; if (busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_busy_err: got %b%b want 00", busy, err); end
        tick(); tick();
        req = '0; tcdm_gnt = 1'b0; tcdm_r_valid = 1'b0;
        rst = 1'b0;
        settle();
        total++; if (busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL post_reset_busy_err: got %b%b want 00", busy, err); end
        tick();
    endtask

    task automatic test_single_read;
        add[0] = 32'h100; add[2] = 32'h200; wen[0] = 1'b1;
        req = 4'b0001; tcdm_gnt = 1'b0;
        settle();
        total++; if (tcdm_req !== 1'b1 || tcdm_add !== 32'h100) begin bad++; $display("FAIL single_issue: got req=%b add=%h want 1 100", tcdm_req, tcdm_add); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_nogrant: got %b want 0000", gnt); end
        tick();
        req = 4'b0101;
        settle();
        total++; if (tcdm_add !== 32'h100 || busy !== 1'b1) begin bad++; $display("FAIL single_wait_lock: got add=%h busy=%b want 100 1", tcdm_add, busy); end
        tick();
        tcdm_gnt = 1'b1;
        settle();
        total++; if (gnt !== 4'b0001 || tcdm_wen !== 1'b1 || tcdm_add !== 32'h100) begin bad++; $display("FAIL single_grant: got gnt=%b wen=%b add=%h want 0001 1 100", gnt, tcdm_wen, tcdm_add); end
        tick();
        req = '0; tcdm_gnt = 1'b0; tcdm_r_valid = 1'b1; tcdm_r_data = 32'hCAFE;
        settle();
        total++; if (r_valid !== 4'b0001 || r_data !== 32'hCAFE) begin bad++; $display("FAIL single_resp: got rv=%b data=%h want 0001 cafe", r_valid, r_data); end
        tick();
        tcdm_r_valid = 1'b0;
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b want 0", busy); end
        tick();
        set_payloads();
    endtask

    task automatic test_fairness;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req = 4'b1111; tcdm_gnt = 1'b1; tcdm_r_valid = (k > 0); tcdm_r_data = 32'hA0 + 32'(k);
            settle();
            total++; if (gnt !== (4'b0001 << (k % 4))) begin bad++; $display("FAIL fair_gnt_%0d: got %b want %b", k, gnt, 4'b0001 << (k % 4)); end
            total++; if (tcdm_add !== 32'h1000 + 32'(k % 4) * 4) begin bad++; $display("FAIL fair_add_%0d: got %h", k, tcdm_add); end
            if (k > 0) begin
                total++; if (r_valid !== (4'b0001 << ((k - 1) % 4))) begin bad++; $display("FAIL fair_rv_%0d: got %b want %b", k, r_valid, 4'b0001 << ((k - 1) % 4)); end
            end else begin
                total++; if (r_valid !== 4'b0000) begin bad++; $display("FAIL fair_rv_0: got %b want 0000", r_valid); end
            end
            tick();
        end
        req = '0; tcdm_gnt = 1'b0; tcdm_r_valid = 1'b1;
        settle();
        total++; if (r_valid !== 4'b1000) begin bad++; $display("FAIL fair_last_rv: got %b want 1000", r_valid); end
        tick();
        tcdm_r_valid = 1'b0;
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fair_idle: got busy=%b want 0", busy); end
        tick();
    endtask

    task automatic test_backpressure;
        logic [3:0] drain_exp [4];
        drain_exp[0] = 4'b0010; drain_exp[1] = 4'b0100; drain_exp[2] = 4'b1000; drain_exp[3] = 4'b0001;
        req = 4'b1111; tcdm_gnt = 1'b1; tcdm_r_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            total++; if (gnt !== (4'b0001 << k)) begin bad++; $display("FAIL bp_gnt_%0d: got %b want %b", k, gnt, 4'b0001 << k); end
            tick();
        end
        settle();
        total++; if (tcdm_req !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL bp_full_stall: got req=%b gnt=%b want 0 0000", tcdm_req, gnt); end
        tick();
        tcdm_r_valid = 1'b1;
        settle();
        total++; if (r_valid !== 4'b0001 || tcdm_req !== 1'b0) begin bad++; $display("FAIL bp_pop_same_cycle: got rv=%b req=%b want 0001 0", r_valid, tcdm_req); end
        tick();
        tcdm_r_valid = 1'b0;
        settle();
        total++; if (tcdm_req !== 1'b1 || gnt !== 4'b0001) begin bad++; $display("FAIL bp_regrant: got req=%b gnt=%b want 1 0001", tcdm_req, gnt); end
        tick();
        req = '0; tcdm_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tcdm_r_valid = 1'b1;
            settle();
            total++; if (r_valid !== drain_exp[k]) begin bad++; $display("FAIL bp_drain_%0d: got %b want %b", k, r_valid, drain_exp[k]); end
            tick();
        end
        tcdm_r_valid = 1'b0;
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle: got busy=%b want 0", busy); end
        tick();
    endtask

    task automatic test_variable_latency;
        req = 4'b0100; tcdm_gnt = 1'b1;
        settle();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL vl_gnt2: got %b want 0100", gnt); end
        tick();
        req = 4'b0001; tcdm_r_valid = 1'b1; tcdm_r_data = 32'h11;
        settle();
        total++; if (gnt !== 4'b0001 || r_valid !== 4'b0100 || r_data !== 32'h11) begin bad++; $display("FAIL vl_push_pop: got gnt=%b rv=%b data=%h want 0001 0100 11", gnt, r_valid, r_data); end
        tick();
        req = '0; tcdm_gnt = 1'b0; tcdm_r_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            total++; if (busy !== 1'b1 || r_valid !== 4'b0000) begin bad++; $display("FAIL vl_wait_%0d: got busy=%b rv=%b want 1 0000", k, busy, r_valid); end
            tick();
        end
        tcdm_r_valid = 1'b1; tcdm_r_data = 32'h22;
        settle();
        total++; if (r_valid !== 4'b0001 || r_data !== 32'h22) begin bad++; $display("FAIL vl_resp2: got rv=%b data=%h want 0001 22", r_valid, r_data); end
        tick();
        tcdm_r_valid = 1'b0;
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL vl_idle: got busy=%b want 0", busy); end
        tick();
    endtask

    task automatic test_error_clear;
        tcdm_r_valid = 1'b1;
        settle();
        total++; if (r_valid !== 4'b0000 || err !== 1'b0) begin bad++; $display("FAIL err_drop: got rv=%b err=%b want 0000 0", r_valid, err); end
        tick();
        tcdm_r_valid = 1'b0;
        settle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err); end
        tick();
        settle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
        tick();
        clear = 1'b1; tick(); clear = 1'b0;
        settle();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err); end
        tick();
        req = 4'b1111; tcdm_gnt = 1'b1;
        settle();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL clear_rr_ptr: got %b want 0001", gnt); end
        tick();
        req = '0; tcdm_gnt = 1'b0; tcdm_r_valid = 1'b1;
        settle();
        total++; if (r_valid !== 4'b0001) begin bad++; $display("FAIL clear_resp: got %b want 0001", r_valid); end
        tick();
        tcdm_r_valid = 1'b0;
    endtask

    task automatic test_async_reset;
        req = 4'b0001; tcdm_gnt = 1'b0;
        tick();
        settle();
        total++; if (tcdm_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL ar_wait: got req=%b busy=%b want 1 1", tcdm_req, busy); end
        #1 rst = 1'b1;
        #1;
        total++; if (tcdm_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ar_immediate: got req=%b busy=%b want 0 0", tcdm_req, busy); end
        tick();
        rst = 1'b0;
        settle();
        total++; if (tcdm_req !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ar_idle_after: got req=%b busy=%b want 1 0", tcdm_req, busy); end
        req = '0;
        tick();
    endtask

`ifdef MUL_MDC_ARB_PRIO_EN
    task automatic test_prio;
        logic [3:0] rot_exp [4];
        rot_exp[0] = 4'b0010; rot_exp[1] = 4'b0100; rot_exp[2] = 4'b1000; rot_exp[3] = 4'b0010;
        clear = 1'b1; tick(); clear = 1'b0;
        req = 4'b1111; tcdm_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tcdm_r_valid = (k > 0);
            settle();
            total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL prio_gnt0_%0d: got %b want 0001", k, gnt); end
            tick();
        end
        req = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            tcdm_r_valid = 1'b1;
            settle();
            total++; if (gnt !== rot_exp[k]) begin bad++; $display("FAIL prio_rot_%0d: got %b want %b", k, gnt, rot_exp[k]); end
            tick();
        end
        req = '0; tcdm_gnt = 1'b0; tcdm_r_valid = 1'b1;
        tick();
        tcdm_r_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
`ifdef MUL_MDC_ARB_PRIO_EN
        test_prio();
`else
        test_fairness();
        test_backpressure();
`endif
        test_variable_latency();
        test_error_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
